arrow_drawer: RTL and testbench
===============================

Name: arrow_drawer

Overview:
- Parametrised successor to the single-direction arrow plotter in the game UI.
- Draws a one-pixel-wide arrow pointing UP, DOWN, LEFT or RIGHT, selected per draw, into the vga_adapter pixel-write port (x, y, colour, plot).
- Each draw is launched by a start pulse and acknowledged by a one-cycle done pulse.
- Pixel emission is paced by an internal rate divider; erase mode redraws the same shape in black.

Parameters:
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- COLOUR_W, 3, colour width
- ORIGIN_X, 79, tip x coordinate
- ORIGIN_Y, 63, tip y coordinate
- SHAFT_LEN, 8, shaft pixel count including the tip (>=1)
- HEAD_LEN, 4, pixels per head arm (>=1)
- TICKS_PER_PIXEL, 1666667, clk cycles between successive pixels (>=1)
- H_RES, 160, screen width, used only by ARROW_CLIP_EN
- V_RES, 120, screen height, used only by ARROW_CLIP_EN

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request a draw; sampled only in IDLE
- dir  in  2  0=UP, 1=DOWN, 2=LEFT, 3=RIGHT; latched on start
- colour  in  COLOUR_W  draw colour; latched on start
- erase  in  1  1 = draw with colour 0; latched on start
- x  out  X_W  pixel x to vga_adapter
- y  out  Y_W  pixel y to vga_adapter
- colour_out  out  COLOUR_W  pixel colour to vga_adapter
- plot  out  1  one-cycle write strobe per pixel
- busy  out  1  high while a draw is in progress
- done  out  1  one-cycle pulse when a draw completes

Behaviour:
- Reset (synchronous, reset_n=0 at a clk edge): state=IDLE; x=0, y=0, colour_out=0, plot=0, busy=0, done=0; pixel index and tick counter cleared. Reset mid-draw aborts the draw with no done pulse and no further plots.
- FSM states and transitions:
  - IDLE -> SHAFT when start=1. dir, colour and erase are latched; tick counter=0; k=0.
  - SHAFT: k = 0..SHAFT_LEN-1. After the last shaft pixel -> ARM_A with k=1.
  - ARM_A: k = 1..HEAD_LEN. After the last pixel -> ARM_B with k=1.
  - ARM_B: k = 1..HEAD_LEN. After the last pixel -> DONE.
  - DONE -> IDLE unconditionally after one cycle.
- Pacing: in SHAFT, ARM_A and ARM_B, a tick fires when the tick counter equals 0; the counter then reloads TICKS_PER_PIXEL-1, otherwise it decrements. Each tick registers one pixel (x, y, colour_out, plot=1) and advances k/state. plot=0 on all other cycles.
- Pixel geometry (OX=ORIGIN_X, OY=ORIGIN_Y):
  - UP: shaft (OX, OY+k); arm A (OX+k, OY+k); arm B (OX-k, OY+k)
  - DOWN: shaft (OX, OY-k); arm A (OX+k, OY-k); arm B (OX-k, OY-k)
  - LEFT: shaft (OX+k, OY); arm A (OX+k, OY+k); arm B (OX+k, OY-k)
  - RIGHT: shaft (OX-k, OY); arm A (OX-k, OY+k); arm B (OX-k, OY-k)
- Pixel count: N = SHAFT_LEN + 2*HEAD_LEN. The tip is plotted once in SHAFT; arms start at k=1.
- Coordinate arithmetic is modulo 2^X_W / 2^Y_W. There is no clipping unless ARROW_CLIP_EN is defined.
- colour_out = 0 when the latched erase=1, otherwise the latched colour.
- Timing, with start sampled high at the end of cycle c0:
  - pixel i (0..N-1) has plot high in cycle c0+1+i*T, where T=TICKS_PER_PIXEL
  - done is high only in cycle c0+1+(N-1)*T+1
  - busy is high from cycle c0+1 through the done cycle inclusive
- start while busy, including the DONE cycle, is ignored and not queued. Changes to dir/colour/erase while busy have no effect.
- Back-to-back draws: start high in the first IDLE cycle after done is accepted.

Optional Feature:
- Macro ARROW_CLIP_EN.
- Defined: a pixel with x >= H_RES or y >= V_RES (after wrap) keeps its tick slot, but plot stays 0 for that slot. Timing, busy and done are unchanged.
- Undefined: every pixel is plotted with wrapped coordinates. H_RES and V_RES are unused.

Test Plan:
- Defaults with TICKS_PER_PIXEL=1; start, dir=UP, colour=3'b100 -> 16 plot pulses on consecutive cycles: (79,63..70), (80..83,64..67), (78..75,64..67); colour_out=4; done one cycle later; busy high for 17 cycles.
- dir=LEFT, then dir=RIGHT, then dir=DOWN, each with erase=1 -> coordinates match the geometry table for each direction; colour_out=0 on all plots.
- TICKS_PER_PIXEL=3, dir=UP -> plot pulses 3 cycles apart (cycles c0+1, c0+4, ..., c0+46); done at c0+47.
- start re-pulsed mid-draw and during the DONE cycle, with dir toggled -> ignored; pixels still follow the latched dir; exactly one done; a new start in the following IDLE cycle is accepted.
- reset_n=0 for one cycle after the 5th plot -> plot, busy and done are 0 from the next cycle; no done pulse; a fresh start draws all 16 pixels.
- ARROW_CLIP_EN with ORIGIN_X=2, dir=UP -> arm B pixels x=1, 0 plotted; k=3, 4 (x=255, 254) give plot=0; total of 14 plot pulses; done timing unchanged.

Source files
------------

// File: rtl/arrow_drawer.sv
// Paced arrow plotter for the vga_adapter pixel port: shaft, arm A, arm B, then a done pulse.
// Optional `ARROW_CLIP_EN suppresses plot for pixels that fall off the H_RES x V_RES screen.
module arrow_drawer #(
   parameter int X_W             = 8,
   parameter int Y_W             = 7,
   parameter int COLOUR_W        = 3,
   parameter int ORIGIN_X        = 79,
   parameter int ORIGIN_Y        = 63,
   parameter int SHAFT_LEN       = 8,
   parameter int HEAD_LEN        = 4,
   parameter int TICKS_PER_PIXEL = 1666667,
   parameter int H_RES           = 160,
   parameter int V_RES           = 120
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [1:0]          dir,
   input  logic [COLOUR_W-1:0] colour,
   input  logic                erase,
   output logic [X_W-1:0]      x,
   output logic [Y_W-1:0]      y,
   output logic [COLOUR_W-1:0] colour_out,
   output logic                plot,
   output logic                busy,
   output logic                done
);

   localparam int KMAX = (SHAFT_LEN > HEAD_LEN) ? SHAFT_LEN : HEAD_LEN;
   localparam int KW   = $clog2(KMAX + 1);
   localparam int CW   = $clog2(TICKS_PER_PIXEL + 1);
   localparam logic [CW-1:0]  RELOAD     = CW'(TICKS_PER_PIXEL - 1);
   localparam logic [KW-1:0]  SHAFT_LAST = KW'(SHAFT_LEN - 1);
   localparam logic [KW-1:0]  HEAD_LAST  = KW'(HEAD_LEN);
   localparam logic [X_W-1:0] OX         = X_W'(ORIGIN_X);
   localparam logic [Y_W-1:0] OY         = Y_W'(ORIGIN_Y);

   // state names the segment of the NEXT pixel to emit; pixel 0 is emitted on the start edge
   typedef enum logic [2:0] {IDLE, SHAFT, ARM_A, ARM_B, DONE} state_t;

   state_t              state, state_n, pseg;
   logic [KW-1:0]       k, k_n, pk;
   logic [CW-1:0]       cnt, cnt_n;
   logic [1:0]          dir_q, dsel;
   logic [COLOUR_W-1:0] colour_q, csel;
   logic                erase_q, esel;
   logic                emit, accept, busy_n, done_n, vis;
   logic [X_W-1:0]      px, kx, arm_x;
   logic [Y_W-1:0]      py, ky, arm_y;

   always_comb begin
      state_n = state;
      k_n     = k;
      cnt_n   = cnt;
      emit    = 1'b0;
      accept  = 1'b0;
      pseg    = SHAFT;
      pk      = k;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            // busy is still high in the cycle carrying done, which blocks a start there
            if (start && !busy) begin
               accept = 1'b1;
               emit   = 1'b1;
               pk     = '0;
            end else begin
               state_n = IDLE;
            end
         end
         SHAFT, ARM_A, ARM_B: begin
            busy_n = 1'b1;
            pseg   = state;
            if (cnt == '0) begin
               emit = 1'b1;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         DONE: begin
            busy_n  = 1'b1;
            done_n  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (emit) begin
         busy_n = 1'b1;
         cnt_n  = RELOAD;
         case (pseg)
            SHAFT: begin
               if (pk == SHAFT_LAST) begin
                  state_n = ARM_A;
                  k_n     = KW'(1);
               end else begin
                  state_n = SHAFT;
                  k_n     = pk + KW'(1);
               end
            end
            ARM_A: begin
               if (pk == HEAD_LAST) begin
                  state_n = ARM_B;
                  k_n     = KW'(1);
               end else begin
                  state_n = ARM_A;
                  k_n     = pk + KW'(1);
               end
            end
            ARM_B: begin
               if (pk == HEAD_LAST) begin
                  state_n = DONE;
                  k_n     = '0;
               end else begin
                  state_n = ARM_B;
                  k_n     = pk + KW'(1);
               end
            end
            default: state_n = IDLE;
         endcase
      end else begin
         pk = pk;
      end
   end

   always_comb begin
      dsel  = accept ? dir : dir_q;
      csel  = accept ? colour : colour_q;
      esel  = accept ? erase : erase_q;
      kx    = X_W'(pk);
      ky    = Y_W'(pk);
      arm_x = '0;
      arm_y = '0;
      if (pseg == ARM_A) begin
         arm_x = kx;
         arm_y = ky;
      end else if (pseg == ARM_B) begin
         arm_x = -kx;
         arm_y = -ky;
      end else begin
         arm_x = '0;
         arm_y = '0;
      end
      case (dsel)
         2'd0:    begin px = OX + arm_x; py = OY + ky;    end
         2'd1:    begin px = OX + arm_x; py = OY - ky;    end
         2'd2:    begin px = OX + kx;    py = OY + arm_y; end
         default: begin px = OX - kx;    py = OY + arm_y; end
      endcase
`ifdef ARROW_CLIP_EN
      vis = (int'(px) < H_RES) && (int'(py) < V_RES);
`else
      vis = 1'b1;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         k          <= '0;
         cnt        <= '0;
         dir_q      <= 2'd0;
         colour_q   <= '0;
         erase_q    <= 1'b0;
         x          <= '0;
         y          <= '0;
         colour_out <= '0;
         plot       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state <= state_n;
         k     <= k_n;
         cnt   <= cnt_n;
         busy  <= busy_n;
         done  <= done_n;
         if (accept) begin
            dir_q    <= dir;
            colour_q <= colour;
            erase_q  <= erase;
         end
         if (emit) begin
            x          <= px;
            y          <= py;
            colour_out <= esel ? '0 : csel;
            plot       <= vis;
         end else begin
            plot <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arrow_drawer.sv
// Bench for arrow_drawer: a per-cycle expectation table built from the geometry/timing rules
// is compared against two instances (T=1 default origin, T=3 with ORIGIN_X=2 for wrap).
module tb_arrow_drawer;
   localparam int MAXC = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       start_a, start_b, erase_a, erase_b;
   logic [1:0] dir_a, dir_b;
   logic [2:0] col_a, col_b, co_a, co_b;
   logic [7:0] x_a, x_b;
   logic [6:0] y_a, y_b;
   logic       plot_a, plot_b, busy_a, busy_b, done_a, done_b;

   arrow_drawer #(.TICKS_PER_PIXEL(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .start(start_a), .dir(dir_a), .colour(col_a), .erase(erase_a),
      .x(x_a), .y(y_a), .colour_out(co_a), .plot(plot_a), .busy(busy_a), .done(done_a));

   arrow_drawer #(.ORIGIN_X(2), .TICKS_PER_PIXEL(3)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(start_b), .dir(dir_b), .colour(col_b), .erase(erase_b),
      .x(x_b), .y(y_b), .colour_out(co_b), .plot(plot_b), .busy(busy_b), .done(done_b));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   logic       exp_plot [2][MAXC];
   logic       exp_busy [2][MAXC];
   logic       exp_done [2][MAXC];
   logic [7:0] exp_x    [2][MAXC];
   logic [6:0] exp_y    [2][MAXC];
   logic [2:0] exp_c    [2][MAXC];
   int         done_cycle [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Expected pixel schedule of one accepted draw starting with start high in cycle c0.
   task automatic model_draw(input int u, input int c0, input logic [1:0] d,
                             input logic [2:0] col, input logic e);
      int t, ox, n, idx, a, dx, dy, klo, khi, dc;
      logic [7:0] xw;
      logic [6:0] yw;
      logic vis;
      t  = (u == 0) ? 1 : 3;
      ox = (u == 0) ? 79 : 2;
      n  = 0;
      for (int s = 0; s < 3; s++) begin
         klo = (s == 0) ? 0 : 1;
         khi = (s == 0) ? 7 : 4;
         for (int k = klo; k <= khi; k++) begin
            a = (s == 0) ? 0 : ((s == 1) ? k : -k);
            case (d)
               2'd0:    begin dx = a;  dy = k;  end
               2'd1:    begin dx = a;  dy = -k; end
               2'd2:    begin dx = k;  dy = a;  end
               default: begin dx = -k; dy = a;  end
            endcase
            xw  = 8'(ox + dx);
            yw  = 7'(63 + dy);
            vis = 1'b1;
`ifdef ARROW_CLIP_EN
            vis = (xw < 8'd160) && (yw < 7'd120);
`endif
            idx = c0 + 1 + n * t;
            if (idx < MAXC) begin
               exp_plot[u][idx] = vis;
               exp_x[u][idx]    = xw;
               exp_y[u][idx]    = yw;
               exp_c[u][idx]    = e ? 3'd0 : col;
            end
            n++;
         end
      end
      dc = c0 + 1 + (n - 1) * t + 1;
      if (dc < MAXC) exp_done[u][dc] = 1'b1;
      for (int c = c0 + 1; c <= dc && c < MAXC; c++) exp_busy[u][c] = 1'b1;
      done_cycle[u] = dc;
   endtask

   // Reset sampled at the end of cycle r wipes everything scheduled after it.
   task automatic model_reset(input int r);
      for (int u = 0; u < 2; u++) begin
         for (int c = r + 1; c < MAXC; c++) begin
            exp_plot[u][c] = 1'b0;
            exp_busy[u][c] = 1'b0;
            exp_done[u][c] = 1'b0;
         end
         done_cycle[u] = r;
      end
   endtask

   task automatic launch(input int u, input logic [1:0] d, input logic [2:0] col, input logic e);
      if (u == 0) begin
         start_a = 1'b1; dir_a = d; col_a = col; erase_a = e;
      end else begin
         start_b = 1'b1; dir_b = d; col_b = col; erase_b = e;
      end
      if (cyc > done_cycle[u]) model_draw(u, cyc, d, col, e);
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_cyc(input int target);
      int guard;
      guard = 0;
      while (cyc < target && guard < 2000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (cyc < target) check("wait_bound", cyc, target);
   endtask

   always @(negedge clk) begin
      if (chk_en && cyc < MAXC) begin
         check("plot_a", plot_a, exp_plot[0][cyc]);
         check("busy_a", busy_a, exp_busy[0][cyc]);
         check("done_a", done_a, exp_done[0][cyc]);
         if (exp_plot[0][cyc]) begin
            check("x_a", x_a, exp_x[0][cyc]);
            check("y_a", y_a, exp_y[0][cyc]);
            check("colour_a", co_a, exp_c[0][cyc]);
         end
         check("plot_b", plot_b, exp_plot[1][cyc]);
         check("busy_b", busy_b, exp_busy[1][cyc]);
         check("done_b", done_b, exp_done[1][cyc]);
         if (exp_plot[1][cyc]) begin
            check("x_b", x_b, exp_x[1][cyc]);
            check("y_b", y_b, exp_y[1][cyc]);
            check("colour_b", co_b, exp_c[1][cyc]);
         end
      end
   end

   initial begin
      int c0, c1, c2, c3;
      for (int u = 0; u < 2; u++) begin
         for (int c = 0; c < MAXC; c++) begin
            exp_plot[u][c] = 1'b0; exp_busy[u][c] = 1'b0; exp_done[u][c] = 1'b0;
            exp_x[u][c] = 8'd0; exp_y[u][c] = 7'd0; exp_c[u][c] = 3'd0;
         end
      end
      done_cycle[0] = -1;
      done_cycle[1] = -1;
      reset_n = 1'b0;
      start_a = 1'b0; start_b = 1'b0; erase_a = 1'b0; erase_b = 1'b0;
      dir_a = 2'd0; dir_b = 2'd0; col_a = 3'd0; col_b = 3'd0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_x_a", x_a, 8'd0);
      check("rst_y_a", y_a, 7'd0);
      check("rst_colour_a", co_a, 3'd0);
      check("rst_plot_a", plot_a, 1'b0);
      check("rst_busy_a", busy_a, 1'b0);
      check("rst_done_a", done_a, 1'b0);
      check("rst_x_b", x_b, 8'd0);
      check("rst_busy_b", busy_b, 1'b0);
      reset_n = 1'b1;
      chk_en  = 1'b1;
      @(posedge clk);
      #1;

      // UP, colour 4: 16 consecutive pixels, done one cycle after the last
      c0 = cyc;
      launch(0, 2'd0, 3'd4, 1'b0);
      check("pin_tip_x", exp_x[0][c0 + 1], 8'd79);
      check("pin_tip_y", exp_y[0][c0 + 1], 7'd63);
      check("pin_shaft_end_y", exp_y[0][c0 + 8], 7'd70);
      check("pin_armA1_x", exp_x[0][c0 + 9], 8'd80);
      check("pin_armA1_y", exp_y[0][c0 + 9], 7'd64);
      check("pin_armB4_x", exp_x[0][c0 + 16], 8'd75);
      check("pin_armB4_y", exp_y[0][c0 + 16], 7'd67);
      check("pin_colour", exp_c[0][c0 + 16], 3'd4);
      check("pin_done_cycle", done_cycle[0], c0 + 17);
      wait_cyc(done_cycle[0] + 1);

      // erase draws back to back in the other directions
      c0 = cyc;
      launch(0, 2'd2, 3'd7, 1'b1);
      check("pin_left_armB_y", exp_y[0][c0 + 16], 7'd59);
      check("pin_left_armB_x", exp_x[0][c0 + 16], 8'd83);
      wait_cyc(done_cycle[0] + 1);
      launch(0, 2'd3, 3'd5, 1'b1);
      wait_cyc(done_cycle[0] + 1);
      c0 = cyc;
      launch(0, 2'd1, 3'd3, 1'b1);
      check("pin_down_shaft_y", exp_y[0][c0 + 8], 7'd56);
      check("pin_erase_colour", exp_c[0][c0 + 8], 3'd0);
      wait_cyc(done_cycle[0] + 1);

      // T=3 with tip at x=2: pixels 3 cycles apart, arm B wraps below zero
      c1 = cyc;
      launch(1, 2'd0, 3'd2, 1'b0);
      check("pin_b_armB3_x", exp_x[1][c1 + 43], 8'd255);
      check("pin_b_armB4_x", exp_x[1][c1 + 46], 8'd254);
      check("pin_b_done_cycle", done_cycle[1], c1 + 47);
      wait_cyc(done_cycle[1] + 1);

      // start re-pulsed mid-draw and in the done cycle is ignored
      c2 = cyc;
      launch(0, 2'd3, 3'd6, 1'b0);
      wait_cyc(c2 + 6);
      launch(0, 2'd0, 3'd1, 1'b0);
      wait_cyc(done_cycle[0]);
      launch(0, 2'd1, 3'd2, 1'b1);
      check("pin_repulse_done", done_cycle[0], c2 + 17);
      launch(0, 2'd2, 3'd5, 1'b0);
      wait_cyc(done_cycle[0] + 1);

      // reset for one cycle right after the 5th plot, then a fresh full draw
      c3 = cyc;
      launch(0, 2'd0, 3'd4, 1'b0);
      wait_cyc(c3 + 5);
      reset_n = 1'b0;
      model_reset(cyc);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      launch(0, 2'd0, 3'd4, 1'b0);
      wait_cyc(done_cycle[0] + 3);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
